seg7_scan_decoder: RTL

Receives the multiplexed seven-segment display bus (active-low digit selects plus active-low segment lines) driven by the display side of the design and recovers the displayed hexadecimal value. It is the inverse of the hex-to-segment encoder. It filters each digit for stability, decodes the segment pattern back to a nibble, and assembles all eight digits into one 32-bit frame with a one-cycle valid strobe. It sits on the observation/loopback path used for self-check and board-level verification of the display chain.

---
 rtl/seg7_scan_if.sv | 31 +++
 rtl/seg7_scan_decoder.sv | 135 +++++++++++++
 2 files changed

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: the multiplexed seven-segment display bus and the decoded-frame
// outputs recovered from it.
//   an_n        : 8-bit active-low digit select (bit i = digit i)
//   seg_n       : 7-bit active-low segment lines (bit0 = a ... bit6 = g)
//   value       : 32-bit last complete frame, nibble i = digit i
//   err_mask    : digit i held an undecodable pattern in the last frame
//   blank_mask  : digit i was blank (seg_n = 7'h7F) in the last frame
//   frame_valid : one-cycle strobe when value/err_mask/blank_mask update
// Handshake: frame_valid is a push-only strobe with no ready. It is high for
// exactly one cycle in which value/err_mask/blank_mask carry the new frame.
// Those outputs then hold until the next strobe.
// Modports: master = display side (drives the bus, observes results);
//           slave  = decoder.
interface seg7_scan_if;
   logic [7:0]  an_n;
   logic [6:0]  seg_n;
   logic [31:0] value;
   logic [7:0]  err_mask;
   logic [7:0]  blank_mask;
   logic        frame_valid;

   modport master (
      output an_n, seg_n,
      input  value, err_mask, blank_mask, frame_valid
   );

   modport slave (
      input  an_n, seg_n,
      output value, err_mask, blank_mask, frame_valid
   );
endinterface

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers the hexadecimal value shown on a multiplexed
// seven-segment display. Each (an_n, seg_n) pair must persist for
// STABLE_CYCLES sampling edges before it is captured into the digit buffer.
// Once all eight digits have been captured, the buffer is published as one frame.
//   clk : single clock
//   rst : asynchronous active-high reset
//   bus : seg7_scan_if.slave (an_n/seg_n in; value/err_mask/blank_mask/frame_valid out)
// All outputs are registered; no input reaches an output combinationally.
module seg7_scan_decoder #(
   parameter int STABLE_CYCLES = 4   // legal range 2..255
) (
   input  logic        clk,
   input  logic        rst,
   seg7_scan_if.slave  bus
);

   localparam logic [7:0] SAT_CNT = 8'(STABLE_CYCLES);
   localparam logic [7:0] CAP_CNT = 8'(STABLE_CYCLES - 1);

   logic [14:0] prev_q;       // previous {an_n, seg_n} sample
   logic [7:0]  cnt_q;        // saturating run length of the current pair
   logic [31:0] buf_nib_q;
   logic [7:0]  buf_err_q;
   logic [7:0]  buf_blank_q;
   logic [7:0]  seen_q;
   logic        pub_q;        // buffer is complete; publish on the next edge
   logic [31:0] value_q;
   logic [7:0]  err_q;
   logic [7:0]  blank_q;
   logic        valid_q;

   logic [14:0] sample;
   logic        same;
   logic        sel_ok;
   logic [7:0]  sel_bit;
   logic [3:0]  dec_nib;
   logic        dec_err;
   logic        dec_blank;
   logic        capture;
   logic [7:0]  seen_base;
   logic [7:0]  seen_next;
   logic        complete;

   assign sample  = {bus.an_n, bus.seg_n};
   assign same    = (sample == prev_q);
   assign sel_ok  = $onehot(~bus.an_n);
   assign sel_bit = sel_ok ? ~bus.an_n : 8'h00;

   // The counter only reaches STABLE_CYCLES from STABLE_CYCLES-1 on an equal
   // sample, so this fires once per run even if the pair is held forever.
   assign capture = same && (cnt_q == CAP_CNT) && sel_ok;

   // On the publish edge, seen restarts from zero. A capture on that same edge
   // therefore counts toward the next frame.
   assign seen_base = pub_q ? 8'h00 : seen_q;
   assign seen_next = capture ? (seen_base | sel_bit) : seen_base;
   assign complete  = capture && (seen_next == 8'hFF);

   // Inverse of the hex-to-segment encoder (active-low segments).
   always_comb begin
      dec_nib   = 4'h0;
      dec_err   = 1'b0;
      dec_blank = 1'b0;
      case (bus.seg_n)
         7'h40: dec_nib = 4'h0;
         7'h79: dec_nib = 4'h1;
         7'h24: dec_nib = 4'h2;
         7'h30: dec_nib = 4'h3;
         7'h19: dec_nib = 4'h4;
         7'h12: dec_nib = 4'h5;
         7'h02: dec_nib = 4'h6;
         7'h78: dec_nib = 4'h7;
         7'h00: dec_nib = 4'h8;
         7'h10: dec_nib = 4'h9;
         7'h08: dec_nib = 4'hA;
         7'h03: dec_nib = 4'hB;
         7'h46: dec_nib = 4'hC;
         7'h21: dec_nib = 4'hD;
         7'h06: dec_nib = 4'hE;
         7'h0E: dec_nib = 4'hF;
         7'h7F: dec_blank = 1'b1;
         default: dec_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_q      <= {8'hFF, 7'h7F};
         cnt_q       <= 8'd0;
         buf_nib_q   <= 32'h0;
         buf_err_q   <= 8'h00;
         buf_blank_q <= 8'h00;
         seen_q      <= 8'h00;
         pub_q       <= 1'b0;
         value_q     <= 32'h0;
         err_q       <= 8'h00;
         blank_q     <= 8'h00;
         valid_q     <= 1'b0;
      end else begin
         prev_q <= sample;
         if (!same) begin
            cnt_q <= 8'd1;
         end else if (cnt_q < SAT_CNT) begin
            cnt_q <= cnt_q + 8'd1;
         end

         if (capture) begin
            for (int i = 0; i < 8; i++) begin
               if (sel_bit[i]) begin
                  buf_nib_q[i*4 +: 4] <= dec_nib;
                  buf_err_q[i]        <= dec_err;
                  buf_blank_q[i]      <= dec_blank;
               end
            end
         end

         seen_q  <= seen_next;
         pub_q   <= complete;
         valid_q <= pub_q;
         // The buffer read here still holds the completing digit. Any capture
         // on this edge lands in the buffer only after the read.
         if (pub_q) begin
            value_q <= buf_nib_q;
            err_q   <= buf_err_q;
            blank_q <= buf_blank_q;
         end
      end
   end

   assign bus.value       = value_q;
   assign bus.err_mask    = err_q;
   assign bus.blank_mask  = blank_q;
   assign bus.frame_valid = valid_q;

endmodule
